karatsuba_combine: RTL

Pipelined recombination stage sitting directly downstream of the 16-bit Karatsuba partial-product stage. It consumes the three partial products (high, low, middle) of one 16x16 multiply. It produces the correct 32-bit product `P_hi·2^16 + P_mid·2^8 + P_lo` through a two-stage split-carry adder pipeline. Valid/ready handshakes are used on both sides, with full throughput of one product per cycle.

---
 rtl/karatsuba_pkg.sv | 20 ++
 rtl/karatsuba_combine.sv | 104 ++++++++++
 2 files changed

// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: shared constants and the stage-1 entry type for the
// Karatsuba recombination pipeline (karatsuba_combine).
package karatsuba_pkg;
   localparam int KHALF_W = 8;    // half-operand width
   localparam int KPP_W   = 16;   // p_hi / p_lo width
   localparam int KMID_W  = 17;   // p_mid width
   localparam int KRES_W  = 32;   // full product width
   localparam int KACC_W  = 40;   // optional accumulator width

   // Largest p_mid a 16x16 multiply can produce: 2 * 0xFF * 0xFF.
   localparam logic [KMID_W-1:0] KMID_MAX = 17'h1FC02;

   // Stage-1 entry: low half already summed, upper terms waiting for the carry.
   typedef struct packed {
      logic [KPP_W:0]                lo_sum;  // p_lo + (p_mid[7:0] << 8), with carry
      logic [KPP_W-1:0]              hi;      // p_hi
      logic [KMID_W-KHALF_W-1:0]     mid_hi;  // p_mid[16:8]
      logic                          err;     // p_mid out of legal range
   } s1_entry_t;
endpackage

// File: rtl/karatsuba_combine.sv
// karatsuba_combine: two-stage split-carry recombination of Karatsuba
// partial products into P_hi*2^16 + P_mid*2^8 + P_lo.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; p_hi, p_lo (16b), p_mid (17b)
//   out_valid/out_ready downstream handshake; result (32b), out_err
//   acc_clr, acc (40b)  running sum of delivered results, only when the
//                       KCOMB_ACC_EN macro is defined
//
// Stall is global: every stage advances together when the output slot is
// empty or being drained, so in_ready never depends on in_valid.
module karatsuba_combine
   import karatsuba_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [KPP_W-1:0]  p_hi,
   input  logic [KPP_W-1:0]  p_lo,
   input  logic [KMID_W-1:0] p_mid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [KRES_W-1:0] result,
   output logic              out_err
`ifdef KCOMB_ACC_EN
  ,input  logic              acc_clr,
   output logic [KACC_W-1:0] acc
`endif
);
   localparam int LAT = 2;

   logic [LAT:1]      vld_pipe_q, vld_pipe_d;
   s1_entry_t         s1_q, s1_d;
   logic [KRES_W-1:0] res_q, res_d;
   logic              err_q, err_d;
   logic              adv;
   logic [KPP_W-1:0]  hi_sum;

   assign adv       = !vld_pipe_q[LAT] | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe_q[LAT];
   assign result    = res_q;
   assign out_err   = err_q;

   // Upper half picks up the low-half carry; mod 2^16 by construction.
   assign hi_sum = s1_q.hi + KPP_W'(s1_q.mid_hi) + KPP_W'(s1_q.lo_sum[KPP_W]);

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      s1_d       = s1_q;
      res_d      = res_q;
      err_d      = err_q;
      if (adv) begin
         vld_pipe_d = {vld_pipe_q[LAT-1:1], in_valid};
         // Data only loads behind a valid, so bubbles leave held values alone.
         if (vld_pipe_q[1]) begin
            res_d = {hi_sum, s1_q.lo_sum[KPP_W-1:0]};
            err_d = s1_q.err;
         end
         if (in_valid) begin
            s1_d.lo_sum = {1'b0, p_lo} + {1'b0, p_mid[KHALF_W-1:0], {KHALF_W{1'b0}}};
            s1_d.hi     = p_hi;
            s1_d.mid_hi = p_mid[KMID_W-1:KHALF_W];
            s1_d.err    = (p_mid > KMID_MAX);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         s1_q       <= '0;
         res_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         s1_q       <= s1_d;
         res_q      <= res_d;
         err_q      <= err_d;
      end
   end

`ifdef KCOMB_ACC_EN
   logic [KACC_W-1:0] acc_q, acc_d;

   // Clear and accumulate in the same handshake restarts the sum at result.
   always_comb begin
      acc_d = acc_q;
      if (out_valid && out_ready)
         acc_d = (acc_clr ? '0 : acc_q) + KACC_W'(res_q);
      else if (acc_clr)
         acc_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign acc = acc_q;
`endif
endmodule
